// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_sub_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   // 2'b11 is unused and recovers to ST_IDLE in the next-state logic.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor built purely from gate primitives so every
// internal net is a distinct stuck-at fault site.
module full_subtractor (
   output logic diff,
   output logic bout,
   input  logic x,
   input  logic y,
   input  logic bin
);

   logic x_xor_y;
   logic x_n;
   logic x_xor_y_n;
   logic gen_borrow;
   logic prop_borrow;

   xor u_xor_xy   (x_xor_y, x, y);
   xor u_xor_diff (diff, x_xor_y, bin);
   not u_not_x    (x_n, x);
   and u_and_gen  (gen_borrow, x_n, y);
   not u_not_xy   (x_xor_y_n, x_xor_y);
   and u_and_prop (prop_borrow, x_xor_y_n, bin);
   or  u_or_bout  (bout, gen_borrow, prop_borrow);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, d = a - b, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t             state;
   state_t             state_next;
   logic               accept_c;
   logic               last_c;

   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic               borrow;
   logic [CNT_W-1:0]   cnt;
   logic               diff_c;
   logic               bout_c;

`ifdef SERIAL_SUB_OVF_EN
   logic               a_msb;
   logic               b_msb;
`endif

   // Single shared subtractor cell fed by the operand LSBs and the borrow flop.
   full_subtractor u_cell (
      .diff (diff_c),
      .bout (bout_c),
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .bin  (borrow)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; start is only honoured outside RUN.
   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      last_c     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_RUN;
               accept_c   = 1'b1;
            end
         end
         ST_RUN: begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
               state_next = ST_DONE;
               last_c     = 1'b1;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_next = ST_RUN;
               accept_c   = 1'b1;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Handshake outputs, registered from the next state so they align with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_next == ST_RUN);
         done <= last_c;
      end
   end

   // Operand shifters, borrow flop, bit counter and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh       <= '0;
         b_sh       <= '0;
         borrow     <= 1'b0;
         cnt        <= '0;
         d          <= '0;
         borrow_out <= 1'b0;
      end else if (accept_c) begin
         a_sh       <= a;
         b_sh       <= b;
         borrow     <= 1'b0;
         cnt        <= '0;
         d          <= '0;
         borrow_out <= 1'b0;
      end else if (state == ST_RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         d      <= {diff_c, d[WIDTH-1:1]};
         borrow <= bout_c;
         // Counter stops at its final value so it never wraps mid-operation.
         if (!last_c) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (last_c) begin
            borrow_out <= bout_c;
         end
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // Signed overflow: operand signs differ and the result sign differs from a.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept_c) begin
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
         ovf   <= 1'b0;
      end else if (last_c) begin
         ovf <= (a_msb ^ b_msb) & (diff_c ^ a_msb);
      end
   end
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with a scoreboard of expected results.
module tb_serial_subtractor;
   import serial_sub_pkg::*;

   localparam int unsigned W       = DEFAULT_WIDTH;
   localparam int          TIMEOUT = 4 * W + 8;

   typedef struct packed {
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
   } exp_t;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .d          (d),
      .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Arithmetic reference: modular difference, unsigned borrow, signed overflow.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t r;
      r.d  = x - y;
      r.bo = (x < y);
      r.ov = (x[W-1] != y[W-1]) && (r.d[W-1] != x[W-1]);
      return r;
   endfunction

   // Present operands with a one-cycle start pulse; returns at the negedge after the accepting edge.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      a     = x;
      b     = y;
      start = 1'b1;
      sb.push_back(model(x, y));
      @(negedge clk);
      start = 1'b0;
   endtask

   // Bounded wait for done, counting negedges.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < TIMEOUT) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
      n_vec++; if (d !== '0) begin n_err++; $display("FAIL reset_d got %h want 0", d); end
      n_vec++; if (borrow_out !== 1'b0) begin n_err++; $display("FAIL reset_borrow got %b want 0", borrow_out); end
`ifdef SERIAL_SUB_OVF_EN
      n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_vectors();
      logic [W-1:0] va[6];
      logic [W-1:0] vb[6];
      int           cyc;
      exp_t         e;
      va = '{4'd9, 4'd3, 4'd7, 4'hF, 4'd0, 4'd8};
      vb = '{4'd3, 4'd9, 4'd8, 4'hF, 4'd0, 4'd1};
      for (int i = 0; i < 6; i++) begin
         issue(va[i], vb[i]);
         n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL vec%0d_busy got %b want 1", i, busy); end
         wait_done(cyc);
         n_vec++;
         if (done !== 1'b1 || cyc != W) begin
            n_err++; $display("FAIL vec%0d_latency got done=%b after %0d want done=1 after %0d", i, done, cyc, W);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++; if (d !== e.d) begin n_err++; $display("FAIL vec%0d_d got %h want %h", i, d, e.d); end
            n_vec++; if (borrow_out !== e.bo) begin n_err++; $display("FAIL vec%0d_borrow got %b want %b", i, borrow_out, e.bo); end
`ifdef SERIAL_SUB_OVF_EN
            n_vec++; if (ovf !== e.ov) begin n_err++; $display("FAIL vec%0d_ovf got %b want %b", i, ovf, e.ov); end
`endif
         end
         @(negedge clk);
         n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL vec%0d_done_pulse got %b want 0", i, done); end
         n_vec++; if (d !== e.d) begin n_err++; $display("FAIL vec%0d_hold got %h want %h", i, d, e.d); end
      end
   endtask

   task automatic test_start_during_run();
      int   cyc;
      exp_t e;
      issue(4'd9, 4'd3);
      a     = 4'd1;
      b     = 4'd1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      wait_done(cyc);
      n_vec++;
      if (done !== 1'b1 || cyc != W - 2) begin
         n_err++; $display("FAIL run_start_latency got done=%b after %0d want done=1 after %0d", done, cyc, W - 2);
      end
      e = sb.pop_front();
      n_vec++; if (d !== e.d) begin n_err++; $display("FAIL run_start_d got %h want %h", d, e.d); end
      n_vec++; if (borrow_out !== e.bo) begin n_err++; $display("FAIL run_start_borrow got %b want %b", borrow_out, e.bo); end
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL run_start_idle got busy=%b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int   cyc;
      exp_t e;
      issue(4'd9, 4'd3);
      wait_done(cyc);
      e = sb.pop_front();
      n_vec++; if (d !== e.d) begin n_err++; $display("FAIL b2b_first_d got %h want %h", d, e.d); end
      // Start asserted during the DONE cycle itself.
      a     = 4'd2;
      b     = 4'd1;
      start = 1'b1;
      sb.push_back(model(4'd2, 4'd1));
      @(negedge clk);
      start = 1'b0;
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", busy); end
      wait_done(cyc);
      n_vec++;
      if (done !== 1'b1 || cyc != W) begin
         n_err++; $display("FAIL b2b_latency got done=%b after %0d want done=1 after %0d", done, cyc, W);
      end
      e = sb.pop_front();
      n_vec++; if (d !== e.d) begin n_err++; $display("FAIL b2b_second_d got %h want %h", d, e.d); end
      n_vec++; if (borrow_out !== e.bo) begin n_err++; $display("FAIL b2b_second_borrow got %b want %b", borrow_out, e.bo); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      int   cyc;
      exp_t e;
      issue(4'd9, 4'd3);
      @(negedge clk);
      rst_n = 1'b0;
      void'(sb.pop_back());
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
      n_vec++; if (d !== '0) begin n_err++; $display("FAIL abort_d got %h want 0", d); end
      n_vec++; if (borrow_out !== 1'b0) begin n_err++; $display("FAIL abort_borrow got %b want 0", borrow_out); end
      // Start held high across the release edge: accepted on the first edge after release.
      a     = 4'd5;
      b     = 4'd2;
      start = 1'b1;
      sb.push_back(model(4'd5, 4'd2));
      repeat (2) begin
         @(negedge clk);
         n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b want 0", done); end
      end
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL release_start got busy=%b want 1", busy); end
      wait_done(cyc);
      n_vec++;
      if (done !== 1'b1 || cyc != W) begin
         n_err++; $display("FAIL release_latency got done=%b after %0d want done=1 after %0d", done, cyc, W);
      end
      e = sb.pop_front();
      n_vec++; if (d !== e.d) begin n_err++; $display("FAIL release_d got %h want %h", d, e.d); end
      n_vec++; if (borrow_out !== e.bo) begin n_err++; $display("FAIL release_borrow got %b want %b", borrow_out, e.bo); end
      @(negedge clk);
   endtask

   task automatic test_random();
      int   cyc;
      exp_t e;
      for (int i = 0; i < 12; i++) begin
         issue(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));
         wait_done(cyc);
         n_vec++;
         if (done !== 1'b1) begin n_err++; $display("FAIL rnd%0d_timeout got done=%b want 1", i, done); end
         e = sb.pop_front();
         n_vec++; if (d !== e.d) begin n_err++; $display("FAIL rnd%0d_d got %h want %h", i, d, e.d); end
         n_vec++; if (borrow_out !== e.bo) begin n_err++; $display("FAIL rnd%0d_borrow got %b want %b", i, borrow_out, e.bo); end
`ifdef SERIAL_SUB_OVF_EN
         n_vec++; if (ovf !== e.ov) begin n_err++; $display("FAIL rnd%0d_ovf got %b want %b", i, ovf, e.ov); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_start_during_run();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      n_vec++;
      if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_serial_subtractor
